hit_judge: RTL
==============

# hit_judge

Scoring back end for the whack-a-mole game. It takes mole events from `light_controller` and key events from `keypad_controller`, and judges each mole as exactly one hit or one miss. It keeps two-digit BCD hit, miss and mole counts for the HEX displays. It raises `game_over` on the deathmatch or maximum-moles end conditions. It sits in `wam` between the two controllers and the display decoders, and replaces the ad-hoc combinational hit recording there.

## Interface
Parameters:
- `NUM_HOLES`, default 9: number of valid light/key positions, 0..NUM_HOLES-1.
- `POS_W`, default 4: width of the position and key codes.

Ports:
- `clk`  in  1: system clock (CLOCK_50).
- `reset`  in  1: synchronous, active-low; when low at a rising edge, all state and outputs clear.
- `start`  in  1: level; high while a game is running.
- `deathmatch`  in  1: when 1, the first miss ends the game.
- `max_moles`  in  6: number of moles per game; 0 means unlimited. Sampled on IDLE→WAIT_MOLE.
- `mole_valid`  in  1: high while a light is on.
- `light_pos`  in  POS_W: index of the lit LED; valid when `mole_valid`=1.
- `key_valid`  in  1: one-cycle pulse per debounced key press.
- `key`  in  POS_W: code of the pressed key; valid with `key_valid`.
- `hit_pulse`  out  1: one-cycle pulse per hit.
- `miss_pulse`  out  1: one-cycle pulse per miss.
- `hits_tens`, `hits_ones`  out  4 each: BCD hit count.
- `miss_tens`, `miss_ones`  out  4 each: BCD miss count.
- `moles_tens`, `moles_ones`  out  4 each: BCD count of moles presented.
- `game_over`  out  1: high in state OVER.

## Operation
States: IDLE, WAIT_MOLE, MOLE_UP, JUDGED, OVER. Reset enters IDLE.

- **IDLE**
  - Counters hold their values.
  - `start`=1 → WAIT_MOLE. On this transition, clear all counters and latch `max_moles` into `limit`.
- **WAIT_MOLE**
  - `mole_valid`=1 and `light_pos`<NUM_HOLES: latch `target`=`light_pos`, increment the mole count, go to MOLE_UP.
  - `mole_valid`=1 with `light_pos`≥NUM_HOLES: ignored; stay in WAIT_MOLE.
  - `key_valid` here is ignored, with no penalty.
- **MOLE_UP**, evaluated in this priority order:
  - `key_valid` and `key`==`target`: hit.
  - `key_valid` and `key`!=`target`: miss.
  - `mole_valid`=0 with no key press: miss (timeout).
  - A key press and `mole_valid` falling in the same cycle is judged on the key.
- **After a judgement:**
  - Pulse `hit_pulse` or `miss_pulse`, and increment the matching counter.
  - Next state is OVER if `deathmatch`=1 and the judgement was a miss, or if `limit`≠0 and the mole count equals `limit`.
  - Otherwise, next state is JUDGED when `mole_valid` is still 1, or WAIT_MOLE when it is 0.
- **JUDGED**
  - All key presses are ignored.
  - `mole_valid`=0 → WAIT_MOLE.
  - A mole is judged at most once.
- **OVER**
  - `game_over`=1; counters are frozen; all inputs except `reset` are ignored.
  - Leave only via `reset`.
- **`start`=0** in WAIT_MOLE, MOLE_UP or JUDGED → IDLE with no judgement and no pulse; counters hold.
- **Counters**
  - Two-digit BCD, 00..99. `ones` wraps 9→0 and carries into `tens`.
  - Each counter saturates at 99; no further increments and no wrap to 00.
  - Pulses still fire when a counter is saturated.
- **`deathmatch`** is sampled live at judgement time.

## Timing
- All outputs are registered. Reset values: pulses 0, all BCD digits 0, `game_over` 0, state IDLE.
- Judgement latency:
  - A `key_valid` sampled at edge N gives a pulse high in cycle N+1, with the counter updated at the same edge N.
  - For a timeout, the pulse comes one cycle after the first sampled `mole_valid`=0.
- `game_over` rises at the same edge as the final pulse, so both are high in the same cycle.
- Mole capture: the mole count increments one cycle after `mole_valid` is first sampled high. A key press in that same capture cycle is ignored, because the state is still WAIT_MOLE.
- At most one of `hit_pulse` and `miss_pulse` is high in any cycle, and never in consecutive cycles for the same mole.
- Reset low mid-game: at the next edge everything clears and the state is IDLE, regardless of any other input.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with random inputs → all BCD outputs 0, pulses 0, `game_over` 0. Release with `start`=0 → outputs remain 0.
- **Hit:** `start`=1, `light_pos`=4, `mole_valid`=1 → moles=01. After 10 cycles, press `key`=4 → `hit_pulse` for one cycle, hits=01. A second press of `key`=4 before the light goes off → no pulse, hits stay 01.
- **Miss variants:**
  - `light_pos`=2 and `key`=7 → `miss_pulse`, misses=01, hits=00.
  - Next mole held for 5 cycles with no key, then dropped → `miss_pulse` one cycle later, misses=02.
  - `key`=3 with `light_pos`=3 in the same cycle that `mole_valid` falls → hit.
- **Deathmatch:** `deathmatch`=1, one timeout miss → `game_over`=1 in the same cycle as `miss_pulse`. Further moles and keys → no change. Only `reset` clears it.
- **Limit and BCD:**
  - `max_moles`=12, hit all 12 → hits go 09→10 (tens=1, ones=0) and end at 12. `game_over` is asserted with the 12th `hit_pulse`.
  - `max_moles`=0 with 101 misses → misses saturate at 99.
- **Abort:** drop `start` while in MOLE_UP → IDLE, no pulse. Re-raise `start` → counters clear to 00.

Source files
------------

// File: rtl/hit_judge_if.sv
// Game-side signal bundle for hit_judge: mole/key events and game control
// in, judgement pulses, BCD scores and game_over out.
//   master : controllers / test driver (drive events, observe scores)
//   slave  : hit_judge (consume events, drive scores)
interface hit_judge_if #(
  parameter int unsigned POS_W = 4
);
  logic             start;
  logic             deathmatch;
  logic [5:0]       max_moles;
  logic             mole_valid;
  logic [POS_W-1:0] light_pos;
  logic             key_valid;
  logic [POS_W-1:0] key;
  logic             hit_pulse;
  logic             miss_pulse;
  logic [3:0]       hits_tens;
  logic [3:0]       hits_ones;
  logic [3:0]       miss_tens;
  logic [3:0]       miss_ones;
  logic [3:0]       moles_tens;
  logic [3:0]       moles_ones;
  logic             game_over;

  modport master (
    output start, deathmatch, max_moles, mole_valid, light_pos, key_valid, key,
    input  hit_pulse, miss_pulse, hits_tens, hits_ones, miss_tens, miss_ones,
           moles_tens, moles_ones, game_over
  );

  modport slave (
    input  start, deathmatch, max_moles, mole_valid, light_pos, key_valid, key,
    output hit_pulse, miss_pulse, hits_tens, hits_ones, miss_tens, miss_ones,
           moles_tens, moles_ones, game_over
  );
endinterface

// File: rtl/hit_judge.sv
// Whack-a-mole scoring back end. Judges every presented mole exactly once as
// a hit or a miss, keeps saturating two-digit BCD hit/miss/mole counts and
// flags game_over on a deathmatch miss or when the mole limit is reached.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : hit_judge_if.slave (game inputs, pulses, BCD scores, game_over)
module hit_judge #(
  parameter int unsigned NUM_HOLES = 9,
  parameter int unsigned POS_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  hit_judge_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOLE,
    S_MOLE_UP,
    S_JUDGED,
    S_OVER
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hits_q, hits_d;     // {tens, ones}
  logic [7:0]       miss_q, miss_d;
  logic [7:0]       moles_q, moles_d;
  logic [5:0]       limit_q, limit_d;
  logic [POS_W-1:0] target_q, target_d;
  logic             hit_q, hit_d;
  logic             missp_q, missp_d;
  logic             over_q, over_d;

  logic             pos_ok_c;
  logic             key_hit_c;
  logic             limit_hit_c;
  logic [6:0]       moles_bin_c;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Positions at or above NUM_HOLES are not real lights.
  assign pos_ok_c    = {1'b0, bus.light_pos} < (POS_W + 1)'(NUM_HOLES);
  assign key_hit_c   = bus.key_valid && (bus.key == target_q);
  // Mole count in binary; the count already includes the mole being judged.
  assign moles_bin_c = (7'(moles_q[7:4]) * 7'd10) + 7'(moles_q[3:0]);
  assign limit_hit_c = (limit_q != 6'd0) && (moles_bin_c == 7'(limit_q));

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d  = state_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    moles_d  = moles_q;
    limit_d  = limit_q;
    target_d = target_q;
    hit_d    = 1'b0;
    missp_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT_MOLE;
          hits_d  = 8'h00;
          miss_d  = 8'h00;
          moles_d = 8'h00;
          limit_d = bus.max_moles;
        end
      end

      S_WAIT_MOLE: begin
        if (!bus.start) begin
          state_d = S_IDLE;
        end else if (bus.mole_valid && pos_ok_c) begin
          target_d = bus.light_pos;
          moles_d  = bcd_inc(moles_q);
          state_d  = S_MOLE_UP;
        end
      end

      S_MOLE_UP: begin
        if (!bus.start) begin
          state_d = S_IDLE;
        end else if (bus.key_valid || !bus.mole_valid) begin
          // A key press wins over a simultaneous light-off.
          if (key_hit_c) begin
            hit_d  = 1'b1;
            hits_d = bcd_inc(hits_q);
          end else begin
            missp_d = 1'b1;
            miss_d  = bcd_inc(miss_q);
          end
          if ((bus.deathmatch && !key_hit_c) || limit_hit_c)
            state_d = S_OVER;
          else if (bus.mole_valid)
            state_d = S_JUDGED;
          else
            state_d = S_WAIT_MOLE;
        end
      end

      S_JUDGED: begin
        if (!bus.start)
          state_d = S_IDLE;
        else if (!bus.mole_valid)
          state_d = S_WAIT_MOLE;
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    over_d = (state_d == S_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hits_q   <= 8'h00;
      miss_q   <= 8'h00;
      moles_q  <= 8'h00;
      limit_q  <= 6'd0;
      target_q <= '0;
      hit_q    <= 1'b0;
      missp_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      moles_q  <= moles_d;
      limit_q  <= limit_d;
      target_q <= target_d;
      hit_q    <= hit_d;
      missp_q  <= missp_d;
      over_q   <= over_d;
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = missp_q;
  assign bus.hits_tens  = hits_q[7:4];
  assign bus.hits_ones  = hits_q[3:0];
  assign bus.miss_tens  = miss_q[7:4];
  assign bus.miss_ones  = miss_q[3:0];
  assign bus.moles_tens = moles_q[7:4];
  assign bus.moles_ones = moles_q[3:0];
  assign bus.game_over  = over_q;

endmodule
